// File: rtl/exe_mul_controller_pkg.sv
// Shared constants and helpers for the execute-stage multiply sequencer.
// Flag vectors use the N/C/Z/V bit order of the status register.
package exe_mul_controller_pkg;

    localparam int MUL_CNT_WIDTH = 5;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    localparam int SR_N = 3;
    localparam int SR_C = 2;
    localparam int SR_Z = 1;
    localparam int SR_V = 0;

    // With S set only N and Z follow the result; C and V pass through unchanged.
    function automatic logic [3:0] mul_flags(input logic       s,
                                             input logic [3:0] sr,
                                             input logic       neg,
                                             input logic       zero);
        logic [3:0] f;
        f = sr;
        if (s) begin
            f[SR_N] = neg;
            f[SR_Z] = zero;
        end
        return f;
    endfunction

endpackage

// File: rtl/exe_mul_controller_mul_shift_add_unit.sv
// Radix-2 shift-add datapath: multiplicand, multiplier and accumulator registers.
// acc_next is the accumulator value one iteration ahead, so the caller can register the final sum.
module mul_shift_add_unit #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic                  accumulate,
    input  logic [WORD_WIDTH-1:0] op_a,
    input  logic [WORD_WIDTH-1:0] op_b,
    input  logic [WORD_WIDTH-1:0] acc_in,
    output logic [WORD_WIDTH-1:0] acc_next
);

    logic [WORD_WIDTH-1:0] mcand_reg;
    logic [WORD_WIDTH-1:0] mplier_reg;
    logic [WORD_WIDTH-1:0] acc_reg;

    assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
        end else if (load) begin
            mcand_reg  <= op_a;
            mplier_reg <= op_b;
            acc_reg    <= accumulate ? acc_in : '0;
        end else if (step) begin
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            acc_reg    <= acc_next;
        end
    end

endmodule

// File: rtl/exe_mul_controller.sv
// Multi-cycle MUL/MLA sequencer for the execute stage: stalls the front end for a
// fixed WORD_WIDTH iterations, then strobes the result and flags for one cycle.
module exe_mul_controller
    import exe_mul_controller_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = MUL_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  accumulate,
    input  logic                  s_in,
    input  logic                  flush,
    input  logic [WORD_WIDTH-1:0] op_a,
    input  logic [WORD_WIDTH-1:0] op_b,
    input  logic [WORD_WIDTH-1:0] acc_in,
    input  logic [3:0]            SR_in,
    output logic                  stall,
    output logic [WORD_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic [3:0]            SR_out
);

    mul_state_t            state_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic                  s_reg;
    logic [3:0]            sr_reg;
    logic [WORD_WIDTH-1:0] result_reg;
    logic                  result_valid_reg;
    logic [3:0]            sr_out_reg;

    logic                  accept;
    logic                  step;
    logic                  last_iter;
    logic [WORD_WIDTH-1:0] acc_next;

    assign accept    = (state_reg == MUL_IDLE) && start && !flush;
    assign step      = (state_reg == MUL_RUN) && !flush;
    assign last_iter = (cnt_reg == CNT_WIDTH'(WORD_WIDTH - 1));
    assign stall     = accept || step;

    mul_shift_add_unit #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_shift_add (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (step),
        .accumulate(accumulate),
        .op_a      (op_a),
        .op_b      (op_b),
        .acc_in    (acc_in),
        .acc_next  (acc_next)
    );

    // The final sum is registered on the RUN->DONE edge so result is stable for the whole DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= MUL_IDLE;
            cnt_reg          <= '0;
            s_reg            <= 1'b0;
            sr_reg           <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            sr_out_reg       <= '0;
        end else begin
            result_valid_reg <= 1'b0;
            if (flush) begin
                state_reg <= MUL_IDLE;
            end else begin
                case (state_reg)
                    MUL_IDLE: begin
                        if (start) begin
                            state_reg <= MUL_RUN;
                            cnt_reg   <= '0;
                            s_reg     <= s_in;
                            sr_reg    <= SR_in;
                        end
                    end
                    MUL_RUN: begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (last_iter) begin
                            state_reg        <= MUL_DONE;
                            result_reg       <= acc_next;
                            result_valid_reg <= 1'b1;
                            sr_out_reg       <= mul_flags(s_reg, sr_reg,
                                                          acc_next[WORD_WIDTH-1],
                                                          acc_next == '0);
                        end
                    end
                    MUL_DONE: state_reg <= MUL_IDLE;
                    default:  state_reg <= MUL_IDLE;
                endcase
            end
        end
    end

    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign SR_out       = sr_out_reg;

endmodule

// File: tb/tb_exe_mul_controller.sv
// Scoreboard bench for exe_mul_controller: expected products are queued at issue
// and compared when result_valid strobes; stall length and gaps are checked inline.
module tb_exe_mul_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, accumulate, s_in, flush;
    logic [31:0] op_a, op_b, acc_in;
    logic [3:0]  SR_in;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic [3:0]  SR_out;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  sr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_strobe = 0;
    int   prev_strobe = 0;

    exe_mul_controller dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .accumulate  (accumulate),
        .s_in        (s_in),
        .flush       (flush),
        .op_a        (op_a),
        .op_b        (op_b),
        .acc_in      (acc_in),
        .SR_in       (SR_in),
        .stall       (stall),
        .result      (result),
        .result_valid(result_valid),
        .SR_out      (SR_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && result_valid === 1'b1) begin
            exp_t e;
            prev_strobe = last_strobe;
            last_strobe = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("strobe cyc=%0d result=%h sr=%b exp_result=%h exp_sr=%b",
                         cyc, result, SR_out, e.r, e.sr);
                chk("result", result, e.r);
                chk("sr_out", {28'd0, SR_out}, {28'd0, e.sr});
            end
        end
    end

    // Issue one op starting in the current (IDLE) cycle; returns in the IDLE cycle after DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic accum, input logic s, input logic [3:0] sr);
        exp_t        e;
        logic [31:0] p;
        int          n;
        p    = a * b + (accum ? c : 32'd0);
        e.r  = p;
        e.sr = s ? {p[31], sr[2], (p == 32'd0), sr[0]} : sr;
        sb.push_back(e);
        op_a = a; op_b = b; acc_in = c; accumulate = accum; s_in = s; SR_in = sr;
        start = 1'b1;
        n = 0;
        @(negedge clk);
        while (stall === 1'b1 && n < 100) begin
            n++;
            if (n > 1) begin
                op_a = $urandom; op_b = $urandom; acc_in = $urandom;
                accumulate = 1'($urandom); s_in = 1'($urandom); SR_in = 4'($urandom);
            end
            @(negedge clk);
        end
        chk("stall_cycles", n, 33);
        chk("valid_in_done", {31'd0, result_valid}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; accumulate = 1'b0; s_in = 1'b0; flush = 1'b0;
        op_a = '0; op_b = '0; acc_in = '0; SR_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_sr", {28'd0, SR_out}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 4'b1010);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_result", result, 32'd42);
        chk("hold_sr", {28'd0, SR_out}, 32'b1010);
        @(posedge clk); #1;

        run_op(32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b1, 4'b0101);
        run_op(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 4'b0000);
        run_op(32'd0, 32'h1234, 32'd0, 1'b0, 1'b1, 4'b1111);
        start = 1'b0;
        @(posedge clk); #1;

        // flush and start together: nothing is accepted
        op_a = 32'd11; op_b = 32'd13; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_start_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_start_idle", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;

        // flush at RUN cycle 10
        op_a = 32'd100; op_b = 32'd200; accumulate = 1'b0; start = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_run_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("flush_run_idle", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        run_op(32'd12345, 32'd678, 32'd1000, 1'b1, 1'b0, 4'b0011);
        start = 1'b0;
        @(posedge clk); #1;

        // back-to-back with start held high
        run_op(32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 4'b0000);
        run_op(32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 4'b0000);
        start = 1'b0;
        chk("b2b_gap", last_strobe - prev_strobe, 34);

        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 4'($urandom));
        end
        start = 1'b0;
        @(posedge clk); #1;

        // reset mid-RUN abandons the op
        op_a = 32'd5; op_b = 32'd5; start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_result", result, 32'd0);
        chk("midrst_valid", {31'd0, result_valid}, 32'd0);
        chk("midrst_sr", {28'd0, SR_out}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        repeat (40) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
